// File: rtl/tron_pkg.sv
// Shared types and constants for the frame-buffer write path.
package tron_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    localparam int          FB_WORDS     = 153600;
    localparam logic [3:0]  BG_COLOR_DEF = 4'h8;
    localparam int          FB_ADDR_W    = 19;

    // Both pixels of a word carry the same colour; the upper nibbles are unused.
    function automatic logic [15:0] pack_pixels(input logic [3:0] color);
        return {4'h0, color, 4'h0, color};
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel coordinate to packed-word address (x/2 + y*320) with an out-of-bounds flag.
module fb_addr_calc
    import tron_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [9:0]           x_i,
    input  logic [9:0]           y_i,
    output logic [FB_ADDR_W-1:0] addr_o,
    output logic                 oob_o
);

    localparam logic [31:0] W_LIM = 32'(SCREEN_W);
    localparam logic [31:0] H_LIM = 32'(SCREEN_H);

    logic [FB_ADDR_W-1:0] x_w;
    logic [FB_ADDR_W-1:0] y_w;

    assign x_w = {{(FB_ADDR_W-10){1'b0}}, x_i};
    assign y_w = {{(FB_ADDR_W-10){1'b0}}, y_i};

    // y*320 as two shifts keeps this a pair of adders, no multiplier.
    assign addr_o = (x_w >> 1) + (y_w << 8) + (y_w << 6);
    assign oob_o  = ({22'd0, x_i} >= W_LIM) || ({22'd0, y_i} >= H_LIM);

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port between two trail writers and a screen-clear sweep.
module fb_write_arbiter
    import tron_pkg::*;
#(
    parameter int         SCREEN_W = 640,
    parameter int         SCREEN_H = 480,
    parameter logic [3:0] BG_COLOR = BG_COLOR_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 clear_start,
    input  logic                 blue_req,
    input  logic [9:0]           blue_x,
    input  logic [9:0]           blue_y,
    input  logic [3:0]           blue_color,
    output logic                 blue_gnt,
    input  logic                 red_req,
    input  logic [9:0]           red_x,
    input  logic [9:0]           red_y,
    input  logic [3:0]           red_color,
    output logic                 red_gnt,
    output logic [FB_ADDR_W-1:0] write_address,
    output logic [15:0]          Data_Out,
    output logic                 WE,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 oob_drop
);

    localparam int                   WORDS     = SCREEN_W / 2 * SCREEN_H;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WORDS - 1);

    fb_state_t            state_q, state_d;
    logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic                 last_red_q, last_red_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic                 oob_q, oob_d;

    logic [9:0]           sel_x;
    logic [9:0]           sel_y;
    logic [3:0]           sel_color;
    logic [FB_ADDR_W-1:0] calc_addr;
    logic                 calc_oob;

    always_comb begin
        blue_gnt = 1'b0;
        red_gnt  = 1'b0;
        if (state_q == IDLE && !clear_start) begin
            if (blue_req && (!red_req || last_red_q)) begin
                blue_gnt = 1'b1;
            end else if (red_req) begin
                red_gnt = 1'b1;
            end
        end
    end

    assign sel_x     = red_gnt ? red_x     : blue_x;
    assign sel_y     = red_gnt ? red_y     : blue_y;
    assign sel_color = red_gnt ? red_color : blue_color;

    fb_addr_calc #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_addr_calc (
        .x_i    (sel_x),
        .y_i    (sel_y),
        .addr_o (calc_addr),
        .oob_o  (calc_oob)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        last_red_d = last_red_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        oob_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    // Word 0 is issued on the start edge so the sweep begins the very next cycle.
                    state_d    = CLEAR;
                    clr_addr_d = FB_ADDR_W'(1);
                    we_d       = 1'b1;
                    addr_d     = '0;
                    data_d     = pack_pixels(BG_COLOR);
                end else if (blue_gnt || red_gnt) begin
                    last_red_d = red_gnt;
                    if (calc_oob) begin
                        oob_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = calc_addr;
                        data_d = pack_pixels(sel_color);
                    end
                end
            end
            CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                data_d     = pack_pixels(BG_COLOR);
                clr_addr_d = clr_addr_q + FB_ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            last_red_q <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            last_red_q <= last_red_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            done_q     <= done_d;
            oob_q      <= oob_d;
        end
    end

    assign write_address = addr_q;
    assign Data_Out      = data_q;
    assign WE            = we_q;
    assign clear_busy    = (state_q == CLEAR);
    assign clear_done    = done_q;
    assign oob_drop      = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter, run on a reduced screen so a full clear stays short.
module tb_fb_write_arbiter;

    localparam int         W     = 40;
    localparam int         H     = 10;
    localparam int         WORDS = W / 2 * H;
    localparam logic [3:0] BG    = 4'h8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        clear_start = 1'b0;
    logic        blue_req = 1'b0;
    logic [9:0]  blue_x = '0;
    logic [9:0]  blue_y = '0;
    logic [3:0]  blue_color = '0;
    logic        blue_gnt;
    logic        red_req = 1'b0;
    logic [9:0]  red_x = '0;
    logic [9:0]  red_y = '0;
    logic [3:0]  red_color = '0;
    logic        red_gnt;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        WE;
    logic        clear_busy;
    logic        clear_done;
    logic        oob_drop;

    int          checks = 0;
    int          errors = 0;
    logic [34:0] sb[$];
    logic [34:0] mon_e;
    logic        last_blue = 1'b0;

    always #5 Clk = ~Clk;

    fb_write_arbiter #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .BG_COLOR (BG)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .clear_start   (clear_start),
        .blue_req      (blue_req),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .blue_color    (blue_color),
        .blue_gnt      (blue_gnt),
        .red_req       (red_req),
        .red_x         (red_x),
        .red_y         (red_y),
        .red_color     (red_color),
        .red_gnt       (red_gnt),
        .write_address (write_address),
        .Data_Out      (Data_Out),
        .WE            (WE),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .oob_drop      (oob_drop)
    );

    function automatic logic [34:0] exp_word(input int x, input int y, input logic [3:0] c);
        logic [18:0] a;
        a = 19'(x / 2 + y * 320);
        return {a, 4'h0, c, 4'h0, c};
    endfunction

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // Every write the DUT issues is matched against the scoreboard in order.
    always @(negedge Clk) begin
        if (Reset_n && WE) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", write_address, Data_Out);
            end else begin
                mon_e = sb.pop_front();
                if ({write_address, Data_Out} !== mon_e) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             write_address, Data_Out, mon_e[34:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic test_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (WE !== 1'b0 || write_address !== 19'd0 || Data_Out !== 16'd0) begin
            errors++;
            $display("FAIL reset_port: got WE=%b addr=%0d data=%h, expected 0 0 0", WE, write_address, Data_Out);
        end
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0 || oob_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b oob=%b, expected 0 0 0", clear_busy, clear_done, oob_drop);
        end
        Reset_n = 1'b1;
        last_blue = 1'b0;
        tick();
        checks++;
        if (WE !== 1'b0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got WE=%b busy=%b, expected 0 0", WE, clear_busy);
        end
    endtask

    task automatic test_single();
        blue_req = 1'b1; blue_x = 10'd10; blue_y = 10'd2; blue_color = 4'h3;
        #1;
        checks++;
        if (blue_gnt !== 1'b1 || red_gnt !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: got blue=%b red=%b, expected 1 0", blue_gnt, red_gnt);
        end
        sb.push_back(exp_word(10, 2, 4'h3));
        last_blue = 1'b1;
        tick();
        blue_req = 1'b0;
        checks++;
        if (WE !== 1'b1 || write_address !== 19'd645 || Data_Out !== 16'h0303) begin
            errors++;
            $display("FAIL single_write: got WE=%b addr=%0d data=%h, expected 1 645 0303", WE, write_address, Data_Out);
        end
        tick();
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL single_once: got WE=%b, expected 0", WE);
        end
    endtask

    task automatic test_alternate();
        logic exp_blue;
        blue_req = 1'b1;
        red_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            blue_x = 10'(2 * i + 1); blue_y = 10'(i);     blue_color = 4'(i + 1);
            red_x  = 10'(20 + i);    red_y  = 10'(9 - i); red_color  = 4'(10 + i);
            #1;
            exp_blue = !last_blue;
            checks++;
            if (blue_gnt !== exp_blue || red_gnt !== !exp_blue) begin
                errors++;
                $display("FAIL alt_gnt%0d: got blue=%b red=%b, expected blue=%b red=%b",
                         i, blue_gnt, red_gnt, exp_blue, !exp_blue);
            end
            if (exp_blue) sb.push_back(exp_word(2 * i + 1, i, 4'(i + 1)));
            else          sb.push_back(exp_word(20 + i, 9 - i, 4'(10 + i)));
            last_blue = exp_blue;
            tick();
            checks++;
            if (WE !== 1'b1) begin
                errors++;
                $display("FAIL alt_we%0d: got WE=%b, expected 1", i, WE);
            end
        end
        blue_req = 1'b0;
        red_req  = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL alt_drain: got %0d pending writes, expected 0", sb.size());
        end
    endtask

    task automatic test_clear();
        bit done = 1'b0;
        int busy_cycles = 0;
        int gnt_seen = 0;
        logic exp_blue;
        blue_req = 1'b1; blue_x = 10'd4; blue_y = 10'd1; blue_color = 4'h2;
        red_req  = 1'b1; red_x  = 10'd6; red_y  = 10'd3; red_color  = 4'h5;
        clear_start = 1'b1;
        #1;
        checks++;
        if (blue_gnt !== 1'b0 || red_gnt !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio: got blue=%b red=%b, expected 0 0", blue_gnt, red_gnt);
        end
        for (int i = 0; i < WORDS; i++) sb.push_back({19'(i), 4'h0, BG, 4'h0, BG});
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < WORDS + 10 && !done; c++) begin
            if (clear_done === 1'b1) begin
                done = 1'b1;
                checks++;
                if (clear_busy !== 1'b0 || WE !== 1'b1 || write_address !== 19'(WORDS - 1)) begin
                    errors++;
                    $display("FAIL clear_last: got busy=%b WE=%b addr=%0d, expected 0 1 %0d",
                             clear_busy, WE, write_address, WORDS - 1);
                end
                #1;
                exp_blue = !last_blue;
                checks++;
                if (blue_gnt !== exp_blue || red_gnt !== !exp_blue) begin
                    errors++;
                    $display("FAIL clear_regrant: got blue=%b red=%b, expected blue=%b red=%b",
                             blue_gnt, red_gnt, exp_blue, !exp_blue);
                end
                if (exp_blue) sb.push_back(exp_word(4, 1, 4'h2));
                else          sb.push_back(exp_word(6, 3, 4'h5));
                last_blue = exp_blue;
            end else begin
                if (clear_busy === 1'b1) busy_cycles++;
                if (blue_gnt === 1'b1 || red_gnt === 1'b1) gnt_seen++;
                tick();
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL clear_timeout: got no clear_done within %0d cycles, expected one", WORDS + 10);
        end
        checks++;
        if (busy_cycles != WORDS - 1 || gnt_seen != 0) begin
            errors++;
            $display("FAIL clear_busy: got busy_cycles=%0d grants=%0d, expected %0d 0", busy_cycles, gnt_seen, WORDS - 1);
        end
        tick();
        blue_req = 1'b0;
        red_req  = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clear_drain: got %0d pending writes, expected 0", sb.size());
        end
    endtask

    task automatic test_oob();
        int xs[4] = '{W, 0, W - 1, 1023};
        int ys[4] = '{0, H, H - 1, 1023};
        bit ok[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            red_req = 1'b1; red_x = 10'(xs[i]); red_y = 10'(ys[i]); red_color = 4'h5;
            #1;
            checks++;
            if (red_gnt !== 1'b1 || blue_gnt !== 1'b0) begin
                errors++;
                $display("FAIL oob_gnt%0d: got red=%b blue=%b, expected 1 0", i, red_gnt, blue_gnt);
            end
            last_blue = 1'b0;
            if (ok[i]) sb.push_back(exp_word(xs[i], ys[i], 4'h5));
            tick();
            red_req = 1'b0;
            checks++;
            if (WE !== ok[i] || oob_drop !== !ok[i]) begin
                errors++;
                $display("FAIL oob_out%0d: got WE=%b oob=%b, expected %b %b", i, WE, oob_drop, ok[i], !ok[i]);
            end
            tick();
            checks++;
            if (oob_drop !== 1'b0) begin
                errors++;
                $display("FAIL oob_pulse%0d: got oob=%b, expected 0", i, oob_drop);
            end
        end
    endtask

    task automatic test_clear_restart();
        int done_cnt = 0;
        clear_start = 1'b1;
        for (int i = 0; i < WORDS; i++) sb.push_back({19'(i), 4'h0, BG, 4'h0, BG});
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < WORDS + 20; c++) begin
            clear_start = (WE === 1'b1 && write_address === 19'd100) ? 1'b1 : 1'b0;
            if (clear_done === 1'b1) done_cnt++;
            tick();
        end
        clear_start = 1'b0;
        checks++;
        if (done_cnt != 1 || sb.size() != 0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart: got done=%0d pending=%0d busy=%b, expected 1 0 0", done_cnt, sb.size(), clear_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit hit = 1'b0;
        clear_start = 1'b1;
        for (int i = 0; i < WORDS; i++) sb.push_back({19'(i), 4'h0, BG, 4'h0, BG});
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < WORDS && !hit; c++) begin
            if (WE === 1'b1 && write_address === 19'd50) hit = 1'b1;
            else tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst_reach: got no write of addr 50, expected one");
        end
        sb.delete();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (WE !== 1'b0 || write_address !== 19'd0 || Data_Out !== 16'd0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got WE=%b addr=%0d data=%h busy=%b, expected 0 0 0 0",
                     WE, write_address, Data_Out, clear_busy);
        end
        tick();
        Reset_n = 1'b1;
        last_blue = 1'b0;
        tick();
        checks++;
        if (clear_busy !== 1'b0 || WE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_resume: got busy=%b WE=%b, expected 0 0", clear_busy, WE);
        end
        blue_req = 1'b1; blue_x = 10'd7;  blue_y = 10'd5; blue_color = 4'hC;
        red_req  = 1'b1; red_x  = 10'd12; red_y  = 10'd6; red_color  = 4'h1;
        #1;
        checks++;
        if (blue_gnt !== 1'b1 || red_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_gnt: got blue=%b red=%b, expected 1 0", blue_gnt, red_gnt);
        end
        sb.push_back(exp_word(7, 5, 4'hC));
        last_blue = 1'b1;
        tick();
        blue_req = 1'b0;
        red_req  = 1'b0;
        checks++;
        if (WE !== 1'b1) begin
            errors++;
            $display("FAIL midrst_we: got WE=%b, expected 1", WE);
        end
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_drain: got %0d pending writes, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_clear();
        test_oob();
        test_clear_restart();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
